md_unit: RTL

- Parametrised multiply/divide unit for the pipelined MIPS core; sits in the EX stage beside the ALU.
- Holds the architectural HI/LO registers.
- Models multi-cycle latency with a busy counter so that hazard logic can stall mfhi/mflo/md instructions.
- Supports signed/unsigned mult and div, mthi/mtlo, and a flush that cancels an in-flight operation on exception or interrupt.

---
 rtl/md_unit.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with architectural HI/LO registers for the EX stage.
// Results are computed at accept time, held in pending registers, and committed
// to HI/LO after a fixed busy latency so hazard logic can stall on busy.
// Optional feature macro: MD_MADD_EN enables madd/maddu/msub/msubu (mdop 7-10).
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned PW         = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pend_q, pend_d;
  logic             pend_wr_q, pend_wr_d;    // commit writes HI/LO (cleared for divide by zero)
  logic             pend_acc_q, pend_acc_d;  // commit accumulates into {HI,LO}
  logic             pend_sub_q, pend_sub_d;  // accumulate by subtraction
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Datapath results
  logic [PW-1:0]    prod_s, prod_u;
  logic [WIDTH-1:0] abs_a, abs_b, sdiv_b, udiv_b;
  logic [WIDTH-1:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [PW-1:0]    acc_sum, acc_dif, commit_val;

  // Launch decode
  logic             launch;
  logic [PW-1:0]    launch_val;
  logic [CNT_W-1:0] launch_cyc;
  logic             launch_wr, launch_acc, launch_sub;
  logic             wr_hi, wr_lo;

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Products, quotients and accumulate candidates; divisors forced nonzero to keep X out
  always_comb begin
    prod_s  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    udiv_b  = (b == '0) ? WIDTH'(1) : b;
    q_u     = a / udiv_b;
    r_u     = a % udiv_b;
    abs_a   = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
    abs_b   = b[WIDTH-1] ? (WIDTH'(0) - b) : b;
    sdiv_b  = (abs_b == '0) ? WIDTH'(1) : abs_b;
    q_mag   = abs_a / sdiv_b;
    r_mag   = abs_a % sdiv_b;
    q_s     = (a[WIDTH-1] ^ b[WIDTH-1]) ? (WIDTH'(0) - q_mag) : q_mag;
    r_s     = a[WIDTH-1] ? (WIDTH'(0) - r_mag) : r_mag;
    acc_sum = {hi_q, lo_q} + pend_q;
    acc_dif = {hi_q, lo_q} - pend_q;
    if (pend_acc_q) begin
      commit_val = pend_sub_q ? acc_dif : acc_sum;
    end else begin
      commit_val = pend_q;
    end
  end

  // Decode mdop into a multi-cycle launch or an immediate HI/LO move
  always_comb begin
    launch     = 1'b0;
    launch_val = '0;
    launch_cyc = '0;
    launch_wr  = 1'b1;
    launch_acc = 1'b0;
    launch_sub = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (mdop)
      OP_MULT: begin
        launch     = 1'b1;
        launch_val = prod_s;
        launch_cyc = CNT_W'(MULT_CYCLES);
      end
      OP_MULTU: begin
        launch     = 1'b1;
        launch_val = prod_u;
        launch_cyc = CNT_W'(MULT_CYCLES);
      end
      OP_DIV: begin
        launch     = 1'b1;
        launch_val = {r_s, q_s};
        launch_cyc = CNT_W'(DIV_CYCLES);
        launch_wr  = (b != '0);
      end
      OP_DIVU: begin
        launch     = 1'b1;
        launch_val = {r_u, q_u};
        launch_cyc = CNT_W'(DIV_CYCLES);
        launch_wr  = (b != '0);
      end
      OP_MTHI: wr_hi = 1'b1;
      OP_MTLO: wr_lo = 1'b1;
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        launch     = 1'b1;
        launch_val = ((mdop == OP_MADD) || (mdop == OP_MSUB)) ? prod_s : prod_u;
        launch_cyc = CNT_W'(MULT_CYCLES);
        launch_acc = 1'b1;
        launch_sub = (mdop == OP_MSUB) || (mdop == OP_MSUBU);
      end
`endif
      default: ;
    endcase
  end

  // Next-state: accept while idle, count down while running, commit or cancel at the end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_wr_d  = pend_wr_q;
    pend_acc_d = pend_acc_q;
    pend_sub_d = pend_sub_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          if (launch) begin
            state_d    = ST_RUN;
            cnt_d      = launch_cyc;
            pend_d     = launch_val;
            pend_wr_d  = launch_wr;
            pend_acc_d = launch_acc;
            pend_sub_d = launch_sub;
          end
          if (wr_hi) hi_d = a;
          if (wr_lo) lo_d = a;
        end
      end
      ST_RUN: begin
        if (flush || (cnt_q == CNT_W'(1))) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          pend_d     = '0;
          pend_wr_d  = 1'b0;
          pend_acc_d = 1'b0;
          pend_sub_d = 1'b0;
          if (!flush && pend_wr_q) begin
            {hi_d, lo_d} = commit_val;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, pending result and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_wr_q  <= 1'b0;
      pend_acc_q <= 1'b0;
      pend_sub_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_wr_q  <= pend_wr_d;
      pend_acc_q <= pend_acc_d;
      pend_sub_q <= pend_sub_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule
